que_ctrl: RTL

QUE_CTRL -- requirements
Module: que_ctrl

---
 rtl/que_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/que_ctrl.sv
// Double-ended queue controller with indexed INSERT/DELETE, which use multi-cycle shifts.
// Define QUE_CTRL_OVWR_EN to let pushes and inserts on a full queue overwrite instead of erroring.
module que_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [IW-1:0]          cmd_idx,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [DEPTH*WIDTH-1:0] q_out,
  output logic [IW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PSHF = 3'd1;
  localparam logic [2:0] OP_PSHB = 3'd2;
  localparam logic [2:0] OP_POPF = 3'd3;
  localparam logic [2:0] OP_POPB = 3'd4;
  localparam logic [2:0] OP_INS  = 3'd5;
  localparam logic [2:0] OP_DEL  = 3'd6;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

`ifdef QUE_CTRL_OVWR_EN
  localparam bit OVWR = 1'b1;
`else
  localparam bit OVWR = 1'b0;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r [DEPTH];
  logic [WIDTH-1:0] q_s [DEPTH];
  logic [IW-1:0]    count_r, count_s, ptr_r, ptr_s, idx_r, idx_s, base_s;
  logic [WIDTH-1:0] data_r, data_s, pick_s, last_s;
  logic             del_r, del_s, grow_r, grow_s;
  logic             ready_r, accept_s, full_s, empty_s;
  logic             rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
  logic [WIDTH-1:0] rsp_data_r, rsp_data_s;
  logic             full_r, empty_r;

  // Next-state, queue update and response generation.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    count_s     = count_r;
    ptr_s       = ptr_r;
    idx_s       = idx_r;
    data_s      = data_r;
    del_s       = del_r;
    grow_s      = grow_r;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = ZERO_W;
    accept_s    = cmd_valid & ready_r;
    full_s      = (count_r == IW'(DEPTH));
    empty_s     = (count_r == IW'(0));
    // A full queue under overwrite behaves as if its last entry were already gone.
    base_s      = full_s ? IW'(DEPTH - 1) : count_r;
    pick_s      = ZERO_W;
    last_s      = ZERO_W;
    for (int i = 0; i < DEPTH; i++) begin
      pick_s = (IW'(i) == cmd_idx) ? q_r[i] : pick_s;
      last_s = (IW'(i) == count_r - IW'(1)) ? q_r[i] : last_s;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_NOP: state_s = IDLE;
            OP_PSHF: begin
              if (full_s && !OVWR) begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
              end else begin
                for (int i = 1; i < DEPTH; i++) q_s[i] = q_r[i-1];
                q_s[0]      = cmd_data;
                count_s     = full_s ? count_r : count_r + IW'(1);
                rsp_valid_s = 1'b1;
              end
            end
            OP_PSHB: begin
              if (full_s && !OVWR) begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
              end else if (full_s) begin
                for (int i = 0; i < DEPTH - 1; i++) q_s[i] = q_r[i+1];
                q_s[DEPTH-1] = cmd_data;
                rsp_valid_s  = 1'b1;
              end else begin
                for (int i = 0; i < DEPTH; i++) q_s[i] = (IW'(i) == count_r) ? cmd_data : q_s[i];
                count_s     = count_r + IW'(1);
                rsp_valid_s = 1'b1;
              end
            end
            OP_POPF: begin
              rsp_valid_s = 1'b1;
              if (empty_s) begin
                rsp_err_s = 1'b1;
              end else begin
                for (int i = 0; i < DEPTH - 1; i++) q_s[i] = q_r[i+1];
                q_s[DEPTH-1] = ZERO_W;
                rsp_data_s   = q_r[0];
                count_s      = count_r - IW'(1);
              end
            end
            OP_POPB: begin
              rsp_valid_s = 1'b1;
              if (empty_s) begin
                rsp_err_s = 1'b1;
              end else begin
                for (int i = 0; i < DEPTH; i++) q_s[i] = (IW'(i) == count_r - IW'(1)) ? ZERO_W : q_s[i];
                rsp_data_s = last_s;
                count_s    = count_r - IW'(1);
              end
            end
            OP_INS: begin
              if ((full_s && !OVWR) || (cmd_idx > base_s)) begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
              end else begin
                data_s  = cmd_data;
                idx_s   = cmd_idx;
                del_s   = 1'b0;
                grow_s  = !full_s;
                ptr_s   = base_s;
                state_s = (base_s == cmd_idx) ? WRITE : SHIFT;
              end
            end
            OP_DEL: begin
              if (cmd_idx >= count_r) begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
              end else begin
                data_s  = pick_s;
                idx_s   = cmd_idx;
                del_s   = 1'b1;
                grow_s  = 1'b0;
                ptr_s   = cmd_idx;
                state_s = (cmd_idx == count_r - IW'(1)) ? WRITE : SHIFT;
              end
            end
            default: begin
              rsp_valid_s = 1'b1;
              rsp_err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (del_r) begin
          for (int i = 0; i < DEPTH - 1; i++) q_s[i] = (IW'(i) == ptr_r) ? q_r[i+1] : q_s[i];
          ptr_s   = ptr_r + IW'(1);
          state_s = (ptr_r == count_r - IW'(2)) ? WRITE : SHIFT;
        end else begin
          for (int i = 1; i < DEPTH; i++) q_s[i] = (IW'(i) == ptr_r) ? q_r[i-1] : q_s[i];
          ptr_s   = ptr_r - IW'(1);
          state_s = (ptr_r - IW'(1) == idx_r) ? WRITE : SHIFT;
        end
      end
      WRITE: begin
        rsp_valid_s = 1'b1;
        state_s     = IDLE;
        if (del_r) begin
          for (int i = 0; i < DEPTH; i++) q_s[i] = (IW'(i) == count_r - IW'(1)) ? ZERO_W : q_s[i];
          count_s    = count_r - IW'(1);
          rsp_data_s = data_r;
        end else begin
          for (int i = 0; i < DEPTH; i++) q_s[i] = (IW'(i) == idx_r) ? data_r : q_s[i];
          count_s = grow_r ? count_r + IW'(1) : count_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, queue storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      for (int i = 0; i < DEPTH; i++) q_r[i] <= ZERO_W;
      count_r     <= IW'(0);
      ptr_r       <= IW'(0);
      idx_r       <= IW'(0);
      data_r      <= ZERO_W;
      del_r       <= 1'b0;
      grow_r      <= 1'b0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= ZERO_W;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      count_r     <= count_s;
      ptr_r       <= ptr_s;
      idx_r       <= idx_s;
      data_r      <= data_s;
      del_r       <= del_s;
      grow_r      <= grow_s;
      ready_r     <= (state_s == IDLE);
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_data_r  <= rsp_data_s;
      full_r      <= (count_s == IW'(DEPTH));
      empty_r     <= (count_s == IW'(0));
    end
  end

  // Flatten storage onto the q_out bus, entry 0 in the low bits.
  always_comb begin
    q_out = {DEPTH*WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) q_out[i*WIDTH +: WIDTH] = q_r[i];
  end

  assign cmd_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_data  = rsp_data_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule
